// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch front end. Holds the PC, drives the ROM
//                address, captures the combinational ROM word and buffers
//                {pc, instr} pairs in a small FIFO that drains to the decode
//                stage over a valid/ready handshake. The consumer can
//                redirect, which flushes the FIFO and reloads the PC.
//                Optional macro FETCH_PERF_EN adds fetch/stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [DATA_W-1:0] fetch_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stalls
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_RESET_PC  = ADDR_W'(RESET_PC);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_busy;

    // FIFO status and handshake qualifiers; a redirect suppresses the push
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid && instr_ready;
    assign w_push      = (r_state == FETCH) && !redirect_valid && (!w_full || w_pop);

    // Outputs derive only from registers and FIFO storage
    assign fetch_addr = r_pc;
    assign instr_data = instr_valid ? r_mem_data[r_head] : '0;
    assign instr_pc   = instr_valid ? r_mem_pc[r_head]   : '0;
    assign busy       = w_busy;

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and decoded outputs; redirect never changes state
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_busy = 1'b1;
                if (!enable) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // PC, pointers and occupancy; redirect flushes and reloads with top priority
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc    <= c_RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 1'b1;
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents are don't-care until counted valid
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_tail] <= fetch_data;
            r_mem_pc[r_tail]   <= r_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stalls;
    logic        w_stall;

    assign w_stall      = (r_state == FETCH) && w_full && !w_pop;
    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;

    // Saturating performance counters, cleared by reset and by redirect
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else if (redirect_valid) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_push && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (w_stall && (r_perf_stalls != 16'hFFFF)) begin
                r_perf_stalls <= r_perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer with a queue-based
//                reference model and randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int OBS_W  = 1 + ADDR_W + DATA_W + ADDR_W + 1;

    typedef logic [ADDR_W+DATA_W-1:0] entry_t;

    logic              CLK;
    logic              RST_N;
    logic              enable;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              busy;
`ifdef FETCH_PERF_EN
    logic [15:0]       perf_fetched;
    logic [15:0]       perf_stalls;
`endif

    logic [DATA_W-1:0] rom [2**ADDR_W];

    int errors = 0;
    int checks = 0;

    // Reference model state
    entry_t            m_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic              m_fetch;
    int                m_fetched;
    int                m_stalls;

    logic [OBS_W-1:0] obs;

    fetch_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(0)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .enable        (enable),
        .fetch_addr    (fetch_addr),
        .fetch_data    (fetch_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational ROM
    assign fetch_data = rom[fetch_addr];
    assign obs = {instr_valid, instr_pc, instr_data, fetch_addr, busy};

    function automatic logic [OBS_W-1:0] exp_vec();
        entry_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        return {(m_q.size() != 0), h, m_pc, m_fetch};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc      = '0;
        m_fetch   = 1'b0;
        m_fetched = 0;
        m_stalls  = 0;
    endtask

    // Drive one cycle of inputs and advance the model across the clock edge
    task automatic step(input logic en, input logic rdy, input logic rv,
                        input logic [ADDR_W-1:0] rpc);
        bit pop, push, stall;
        @(negedge CLK);
        enable         = en;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        pop   = (m_q.size() != 0) && rdy;
        push  = m_fetch && !rv && ((m_q.size() < DEPTH) || pop);
        stall = m_fetch && (m_q.size() == DEPTH) && !pop;
        @(posedge CLK);
        if (rv) begin
            m_q.delete();
            m_pc      = rpc;
            m_fetched = 0;
            m_stalls  = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, rom[m_pc]});
                m_pc = m_pc + 1'b1;
                if (m_fetched < 65535) m_fetched++;
            end
            if (stall && m_stalls < 65535) m_stalls++;
        end
        m_fetch = en;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N          = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs !== {OBS_W{1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, {OBS_W{1'b0}});
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_stream();
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 3'd0, 32'hD82C07CD}) begin
            errors++;
            $display("FAIL stream_first: got v=%b pc=%0d d=%h expected v=1 pc=0 d=d82c07cd",
                     instr_valid, instr_pc, instr_data);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({instr_pc, instr_data} !== {3'd1, 32'h6BAA9455}) begin
            errors++;
            $display("FAIL stream_second: got pc=%0d d=%h expected pc=1 d=6baa9455",
                     instr_pc, instr_data);
        end
        // Continue through the wrap: pc 2..7 then 0 again
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stream_wrap[%0d]: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 5) begin
                checks++;
                if ({instr_pc, instr_data} !== {3'd7, 32'hC17C6279}) begin
                    errors++;
                    $display("FAIL wrap_pc7: got pc=%0d d=%h expected pc=7 d=c17c6279",
                             instr_pc, instr_data);
                end
            end
            if (i == 6) begin
                checks++;
                if ({instr_pc, instr_data} !== {3'd0, 32'hD82C07CD}) begin
                    errors++;
                    $display("FAIL wrap_pc0: got pc=%0d d=%h expected pc=0 d=d82c07cd",
                             instr_pc, instr_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if ({fetch_addr, instr_valid, instr_pc} !== {3'd4, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL backpressure_stall: got addr=%0d v=%b pc=%0d expected addr=4 v=1 pc=0",
                     fetch_addr, instr_valid, instr_pc);
        end
        // Full with a single pop: push still happens, head moves to pc 1
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({fetch_addr, instr_pc} !== {3'd5, 3'd1}) begin
            errors++;
            $display("FAIL full_pop: got addr=%0d pc=%0d expected addr=5 pc=1",
                     fetch_addr, instr_pc);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL full_pop_hold: got %h expected %h", obs, exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL drain[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
        // Disable: FIFO keeps draining, no new pushes
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL disable_drain[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 3'd5);
        checks++;
        if ({instr_valid, fetch_addr, busy} !== {1'b0, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b addr=%0d busy=%b expected v=0 addr=5 busy=1",
                     instr_valid, fetch_addr, busy);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 3'd5, 32'h81332876}) begin
            errors++;
            $display("FAIL redirect_refill: got v=%b pc=%0d d=%h expected v=1 pc=5 d=81332876",
                     instr_valid, instr_pc, instr_data);
        end
        // Redirect while idle still reloads and flushes
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        checks++;
        if ({instr_valid, fetch_addr, busy} !== {1'b0, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL redirect_idle: got v=%b addr=%0d busy=%b expected v=0 addr=2 busy=0",
                     instr_valid, fetch_addr, busy);
        end
    endtask

    task automatic test_random();
        logic en, rdy, rv;
        logic [ADDR_W-1:0] rpc;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
            step(en, rdy, rv, rpc);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
            end
`ifdef FETCH_PERF_EN
            checks++;
            if ({perf_fetched, perf_stalls} !== {16'(m_fetched), 16'(m_stalls)}) begin
                errors++;
                $display("FAIL random_perf[%0d]: got f=%0d s=%0d expected f=%0d s=%0d",
                         i, perf_fetched, perf_stalls, m_fetched, m_stalls);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({instr_valid, fetch_addr, busy} !== {1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b addr=%0d busy=%b expected v=0 addr=0 busy=0",
                     instr_valid, fetch_addr, busy);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_fetched, perf_stalls} !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_perf: got f=%0d s=%0d expected 0 0",
                     perf_fetched, perf_stalls);
        end
`endif
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL after_async_reset: got %h expected %h", obs, exp_vec());
        end
    endtask

    initial begin
        rom[0] = 32'hD82C07CD;
        rom[1] = 32'h6BAA9455;
        rom[2] = 32'h1F00AB12;
        rom[3] = 32'h3C5A7E01;
        rom[4] = 32'hA5A50F0F;
        rom[5] = 32'h81332876;
        rom[6] = 32'h0BADF00D;
        rom[7] = 32'hC17C6279;
        RST_N          = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_random();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
